// File: rtl/axi_addr_bit_dropper.sv
// AXI address bit dropper: registered two-entry skid buffers on AW and AR that
// compact or mask a fixed field of address bits at acceptance time. W, R and B
// pass straight through. Saturating counters of accepted AW/AR beats.

// Two-entry skid buffer with a registered upstream ready.
module axi_addr_bit_dropper_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic         ready_q;
  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic         acc, emit;

  assign acc       = s_valid_i & ready_q;
  assign emit      = (state_q != ST_EMPTY) & m_ready_i;
  assign s_ready_o = ready_q;
  assign m_valid_o = (state_q != ST_EMPTY);
  assign m_data_o  = ent0_q;

  // Next-state and entry update; ent0 always holds the oldest beat.
  always_comb begin
    state_d = state_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          ent0_d  = s_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({acc, emit})
          2'b11: ent0_d = s_data_i;
          2'b10: begin
            ent1_d  = s_data_i;
            state_d = ST_FULL;
          end
          2'b01: state_d = ST_EMPTY;
          default: ;
        endcase
      end
      ST_FULL: begin
        if (emit) begin
          ent0_d  = ent1_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Control state; ready is registered from the next state so it stays low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
    end
  end

  // Payload storage needs no reset; validity comes from the state.
  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end
endmodule

module axi_addr_bit_dropper #(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned DROP_LSB   = 12,
  parameter int unsigned DROP_COUNT = 4,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [1:0]              mode,
  // AW
  input  logic [ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic [2:0]              S_AXI_AWSIZE,
  input  logic [1:0]              S_AXI_AWBURST,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  output logic [ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  // AR
  input  logic [ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic [2:0]              S_AXI_ARSIZE,
  input  logic [1:0]              S_AXI_ARBURST,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]              M_AXI_ARLEN,
  output logic [2:0]              M_AXI_ARSIZE,
  output logic [1:0]              M_AXI_ARBURST,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  // W
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  // B
  input  logic [ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  // R
  input  logic [ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RLAST,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_RID,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  // Statistics
  output logic [31:0]             aw_count,
  output logic [31:0]             ar_count
);
  localparam int unsigned PW      = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
  localparam int unsigned DROP_HI = DROP_LSB + DROP_COUNT;
  localparam logic [ADDR_WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ~(ALL_ONES << DROP_LSB);
  localparam logic [ADDR_WIDTH-1:0] DROP_MASK = (ALL_ONES << DROP_LSB) & ~(ALL_ONES << DROP_HI);

  // Shift-and-mask form keeps DROP_LSB = 0 and DROP_HI = ADDR_WIDTH legal.
  function automatic logic [ADDR_WIDTH-1:0] drop_bits(input logic [1:0] md,
                                                      input logic [ADDR_WIDTH-1:0] a);
    case (md)
      2'b01:   return ((a >> DROP_HI) << DROP_LSB) | (a & LOW_MASK);
      2'b10:   return a & ~DROP_MASK;
      default: return a;
    endcase
  endfunction

  logic [PW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [31:0]   aw_cnt_q, ar_cnt_q;

  assign aw_in = {S_AXI_AWID, drop_bits(mode, S_AXI_AWADDR), S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST};
  assign ar_in = {S_AXI_ARID, drop_bits(mode, S_AXI_ARADDR), S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST};
  assign {M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST} = aw_out;
  assign {M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST} = ar_out;

  axi_addr_bit_dropper_skid #(.W(PW)) u_aw_skid (
    .clk(ACLK), .rst_n(ARESETN),
    .s_valid_i(S_AXI_AWVALID), .s_ready_o(S_AXI_AWREADY), .s_data_i(aw_in),
    .m_valid_o(M_AXI_AWVALID), .m_ready_i(M_AXI_AWREADY), .m_data_o(aw_out)
  );

  axi_addr_bit_dropper_skid #(.W(PW)) u_ar_skid (
    .clk(ACLK), .rst_n(ARESETN),
    .s_valid_i(S_AXI_ARVALID), .s_ready_o(S_AXI_ARREADY), .s_data_i(ar_in),
    .m_valid_o(M_AXI_ARVALID), .m_ready_i(M_AXI_ARREADY), .m_data_o(ar_out)
  );

  assign M_AXI_WDATA  = S_AXI_WDATA;
  assign M_AXI_WSTRB  = S_AXI_WSTRB;
  assign M_AXI_WLAST  = S_AXI_WLAST;
  assign M_AXI_WVALID = S_AXI_WVALID;
  assign S_AXI_WREADY = M_AXI_WREADY;
  assign S_AXI_BID    = M_AXI_BID;
  assign S_AXI_BRESP  = M_AXI_BRESP;
  assign S_AXI_BVALID = M_AXI_BVALID;
  assign M_AXI_BREADY = S_AXI_BREADY;
  assign S_AXI_RID    = M_AXI_RID;
  assign S_AXI_RDATA  = M_AXI_RDATA;
  assign S_AXI_RRESP  = M_AXI_RRESP;
  assign S_AXI_RLAST  = M_AXI_RLAST;
  assign S_AXI_RVALID = M_AXI_RVALID;
  assign M_AXI_RREADY = S_AXI_RREADY;

  assign aw_count = aw_cnt_q;
  assign ar_count = ar_cnt_q;

  // Saturating counts of upstream handshakes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_cnt_q <= '0;
      ar_cnt_q <= '0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY && (aw_cnt_q != '1)) aw_cnt_q <= aw_cnt_q + 32'd1;
      if (S_AXI_ARVALID && S_AXI_ARREADY && (ar_cnt_q != '1)) ar_cnt_q <= ar_cnt_q + 32'd1;
    end
  end
endmodule
